// File: rtl/bp_be_payload_skid_fifo_if.sv
// bp_be_payload_skid_fifo_if: producer/consumer handshake bundle for the payload skid FIFO
//   v_i/ready_o/data_i : producer side (valid/ready)
//   v_o/data_o/yumi_i  : consumer side (valid/yumi)
//   modport slave  : the FIFO's view
//   modport master : the driving environment's view
interface bp_be_payload_skid_fifo_if #(parameter int width_p = 221);
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;
  modport slave  (input v_i, data_i, yumi_i, output ready_o, v_o, data_o);
  modport master (output v_i, data_i, yumi_i, input ready_o, v_o, data_o);
endinterface

// File: rtl/bp_be_payload_skid_fifo.sv
// bp_be_payload_skid_fifo: two-entry elastic buffer for wide backend payloads
//   clk_i   : rising-edge clock
//   reset_i : asynchronous active-high reset; discards buffered beats
//   fifo_if : slave modport carrying v_i/ready_o/data_i (producer) and v_o/data_o/yumi_i (consumer)
//   Optional macro BP_BE_SKID_FIFO_BYPASS_EN: an empty FIFO forwards data_i to data_o combinationally.
//   ready_o is always driven straight from a flop.
module bp_be_payload_skid_fifo #(
  parameter int width_p = 221,
  parameter int els_p   = 2
) (
  input logic                      clk_i,
  input logic                      reset_i,
  bp_be_payload_skid_fifo_if.slave fifo_if
);
  if (els_p != 2) begin : g_els_chk
    $error("bp_be_payload_skid_fifo: els_p must be 2");
  end
  if (width_p < 1 || width_p > 1024) begin : g_width_chk
    $error("bp_be_payload_skid_fifo: width_p must be 1..1024");
  end
  logic [width_p-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  // Separate ready flop so ready_o stays low through reset and rises on the first edge after it.
  logic               ready_q;
  logic               enq, deq;
`ifdef BP_BE_SKID_FIFO_BYPASS_EN
  logic byp;
  assign byp            = empty_q & fifo_if.v_i & ready_q;
  // A bypassed beat taken in the same cycle never touches storage.
  assign enq            = fifo_if.v_i & ready_q & ~(byp & fifo_if.yumi_i);
  assign fifo_if.v_o    = ~empty_q | byp;
  assign fifo_if.data_o = byp ? fifo_if.data_i : mem_q[rptr_q];
`else
  assign enq            = fifo_if.v_i & ready_q;
  assign fifo_if.v_o    = ~empty_q;
  assign fifo_if.data_o = mem_q[rptr_q];
`endif
  // yumi_i on an empty FIFO is ignored rather than moving the read pointer.
  assign deq             = fifo_if.yumi_i & ~empty_q;
  assign fifo_if.ready_o = ready_q;
  always_comb begin
    full_d  = full_q;
    empty_d = empty_q;
    if (enq & ~deq) begin
      empty_d = 1'b0;
      full_d  = ~empty_q;
    end else if (deq & ~enq) begin
      full_d  = 1'b0;
      empty_d = ~full_q;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      if (enq) mem_q[wptr_q] <= fifo_if.data_i;
      wptr_q  <= wptr_q ^ enq;
      rptr_q  <= rptr_q ^ deq;
      full_q  <= full_d;
      empty_q <= empty_d;
      ready_q <= ~full_d;
    end
  end
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) fifo_if.yumi_i |-> fifo_if.v_o);
endmodule

// File: tb/tb_bp_be_payload_skid_fifo.sv
// tb_bp_be_payload_skid_fifo: directed self-checking bench for bp_be_payload_skid_fifo
module tb_bp_be_payload_skid_fifo;
  localparam int width_p = 221;
  typedef logic [width_p-1:0] word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  word_t ones, zeros, alt;
  bp_be_payload_skid_fifo_if #(.width_p(width_p)) fifo_if ();
  bp_be_payload_skid_fifo #(.width_p(width_p), .els_p(2)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .fifo_if (fifo_if.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input word_t d, input logic y);
    fifo_if.v_i    = v;
    fifo_if.data_i = d;
    fifo_if.yumi_i = y;
  endtask
  initial begin
    ones  = '1;
    zeros = '0;
    for (int k = 0; k < width_p; k++) alt[k] = ~k[0];
    drive(1'b0, '0, 1'b0);
    edge1();
    edge1();
    chk("rst_ready", word_t'(fifo_if.ready_o), 0);
    chk("rst_v", word_t'(fifo_if.v_o), 0);
    chk("rst_data", fifo_if.data_o, 0);
    // beat offered before ready rises must be dropped
    rst = 1'b0;
    drive(1'b1, 'h55, 1'b0);
    edge1();
    drive(1'b0, '0, 1'b0);
    #1;
    chk("first_ready", word_t'(fifo_if.ready_o), 1);
    chk("early_beat_dropped", word_t'(fifo_if.v_o), 0);
    drive(1'b1, 'h1, 1'b0);
    edge1();
    chk("single_v", word_t'(fifo_if.v_o), 1);
    chk("single_data", fifo_if.data_o, 'h1);
    chk("single_ready", word_t'(fifo_if.ready_o), 1);
    drive(1'b0, '0, 1'b1);
    edge1();
    chk("single_drain", word_t'(fifo_if.v_o), 0);
    drive(1'b1, 'hA, 1'b0);
    edge1();
    drive(1'b1, 'hB, 1'b0);
    edge1();
    chk("fill_ready", word_t'(fifo_if.ready_o), 0);
    chk("fill_head", fifo_if.data_o, 'hA);
    drive(1'b1, 'hC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("hold_ready", word_t'(fifo_if.ready_o), 0);
      chk("hold_head", fifo_if.data_o, 'hA);
    end
    drive(1'b1, 'hC, 1'b1);
    edge1();
    chk("bp_head_b", fifo_if.data_o, 'hB);
    chk("bp_ready_back", word_t'(fifo_if.ready_o), 1);
    edge1();
    chk("bp_head_c", fifo_if.data_o, 'hC);
    chk("bp_v_c", word_t'(fifo_if.v_o), 1);
    drive(1'b0, '0, 1'b1);
    edge1();
    chk("bp_drained", word_t'(fifo_if.v_o), 0);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, word_t'(i), i > 0);
      edge1();
      chk("stream_v", word_t'(fifo_if.v_o), 1);
      chk("stream_data", fifo_if.data_o, word_t'(i));
      chk("stream_ready", word_t'(fifo_if.ready_o), 1);
    end
    drive(1'b0, '0, 1'b1);
    edge1();
    chk("stream_drained", word_t'(fifo_if.v_o), 0);
    drive(1'b1, 'h11, 1'b0);
    edge1();
    drive(1'b1, 'h22, 1'b0);
    edge1();
    drive(1'b0, '0, 1'b0);
    chk("ar_full", word_t'(fifo_if.ready_o), 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_v", word_t'(fifo_if.v_o), 0);
    chk("ar_ready", word_t'(fifo_if.ready_o), 0);
    chk("ar_data", fifo_if.data_o, 0);
    #2 rst = 1'b0;
    edge1();
    chk("ar_ready_back", word_t'(fifo_if.ready_o), 1);
    drive(1'b1, 'h33, 1'b0);
    edge1();
    chk("ar_new_head", fifo_if.data_o, 'h33);
    drive(1'b0, '0, 1'b1);
    edge1();
    chk("ar_no_stale", word_t'(fifo_if.v_o), 0);
    drive(1'b1, ones, 1'b0);
    edge1();
    drive(1'b1, zeros, 1'b0);
    edge1();
    chk("w_ones", fifo_if.data_o, ones);
    chk("w_ones_b220", word_t'(fifo_if.data_o[220]), 1);
    chk("w_ones_b0", word_t'(fifo_if.data_o[0]), 1);
    drive(1'b0, '0, 1'b1);
    edge1();
    chk("w_zeros", fifo_if.data_o, zeros);
    chk("w_zeros_b220", word_t'(fifo_if.data_o[220]), 0);
    drive(1'b1, alt, 1'b1);
    edge1();
    chk("w_alt", fifo_if.data_o, alt);
    chk("w_alt_b220", word_t'(fifo_if.data_o[220]), 1);
    chk("w_alt_b0", word_t'(fifo_if.data_o[0]), 1);
    chk("w_alt_b1", word_t'(fifo_if.data_o[1]), 0);
    drive(1'b0, '0, 1'b1);
    edge1();
    chk("w_drained", word_t'(fifo_if.v_o), 0);
    drive(1'b0, '0, 1'b0);
`ifdef BP_BE_SKID_FIFO_BYPASS_EN
    drive(1'b1, 'h77, 1'b1);
    #1;
    chk("byp_v", word_t'(fifo_if.v_o), 1);
    chk("byp_data", fifo_if.data_o, 'h77);
    edge1();
    drive(1'b0, '0, 1'b0);
    #1;
    chk("byp_still_empty", word_t'(fifo_if.v_o), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_be_payload_skid_fifo.md
Name: bp_be_payload_skid_fifo

Overview:
- Two-entry elastic buffer for wide backend payloads. It sits between a producer that issues valid/ready and a consumer that accepts with valid/yumi.
- It is the drain-side counterpart of the enable-gated reset register used for the 221-bit backend payload. That register only captures on enable; this block lets a downstream stage stall without back-pressuring a producer mid-beat.
- It provides full-throughput streaming with one cycle of latency and registered ready.

Parameters:
- width_p, 221, payload width in bits; legal range 1..1024.
- els_p, 2, entry count; fixed at 2, and other values are a compile-time error.

Ports:
- clk_i  input  1  rising-edge clock for all state.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  producer valid.
- ready_o  output  1  FIFO can accept a beat this cycle; driven from a register, no combinational path from any input.
- data_i  input  width_p  producer payload; sampled only on enqueue.
- v_o  output  1  head entry valid.
- data_o  output  width_p  head entry payload.
- yumi_i  input  1  consumer takes the head this cycle; legal only when v_o=1.

Interface (already decided): one clock, clk_i; reset_i is asynchronous and active-high.

Behaviour:
- State:
  - Storage mem[0..1] of width_p bits.
  - 1-bit write pointer wptr_r and read pointer rptr_r.
  - Flags full_r and empty_r.
- Reset (reset_i=1, asynchronous):
  - wptr_r=rptr_r=0, empty_r=1, full_r=0, mem cleared to 0.
  - Outputs during reset: ready_o=0, v_o=0, data_o=0.
  - ready_o rises on the first clk_i edge after reset_i deasserts. Beats presented before that edge are not accepted.
- Enqueue = v_i & ready_o. On enqueue, mem[wptr_r]<=data_i and wptr_r toggles.
- Dequeue = yumi_i. On dequeue, rptr_r toggles. Head storage is not cleared.
- Outputs: v_o=~empty_r, data_o=mem[rptr_r], ready_o=~full_r (from the flop).
- Occupancy transitions:
  - 0 -> 1 on enqueue only.
  - 1 -> 2 on enqueue without dequeue.
  - 1 -> 0 on dequeue without enqueue.
  - 1 -> 1 on simultaneous enqueue and dequeue. The new beat goes into the other slot and the head advances, so full throughput is sustained.
  - 2 -> 1 on dequeue. Enqueue is impossible at occupancy 2 because ready_o=0.
- Latency: a beat enqueued at edge N is visible on v_o/data_o after edge N. That is one cycle, zero in bypass mode (see Optional Feature).
- Ordering is strict FIFO; no beat is dropped or duplicated.
- v_i while ready_o=0: ignored, no state change. The producer must hold the beat.
- yumi_i while v_o=0: protocol error. The design must ignore it (no pointer move) and simulation asserts fire.
- v_i/data_i may change freely when ready_o=0.
- Reset mid-stream: all buffered beats are discarded immediately, and the outputs take their reset values asynchronously.

Optional Feature:
- Macro: BP_BE_SKID_FIFO_BYPASS_EN.
- When defined, and the FIFO is empty with v_i=1 and ready_o=1:
  - v_o=1 and data_o=data_i combinationally.
  - If yumi_i=1 in the same cycle, the beat is consumed and not written; pointers do not move.
  - If yumi_i=0, the beat is written normally.
- ready_o remains registered either way.
- When undefined: no combinational path from data_i or v_i to any output, and minimum latency is 1 cycle.

Test Plan:
- Reset, then single beat: release reset_i, then v_i=1, data_i=0x1 for one cycle with yumi_i=0 -> next cycle v_o=1, data_o=0x1, ready_o=1; yumi_i=1 -> v_o=0 on the following cycle.
- Fill and back-pressure: enqueue 0xA then 0xB with yumi_i=0 -> ready_o=0. Hold v_i=1 with 0xC for 3 cycles -> no state change. Then yumi_i=1 -> data_o=0xA, next 0xB, next 0xC (after ready_o returns and 0xC is accepted).
- Streaming: v_i=1 and yumi_i=1 every cycle with data 0..99 -> data_o sequence 0..99 with no gaps after the first cycle; ready_o stays 1 throughout.
- Asynchronous reset mid-operation: two beats stored, pulse reset_i between clock edges -> v_o=0, ready_o=0, data_o=0 immediately. After release, the first dequeued beat is the next one enqueued, not a stale one.
- Width boundary: enqueue all-ones then all-zeros, then alternating 0x5..5 across all 221 bits -> exact bit-for-bit match on data_o, with bit 220 and bit 0 checked explicitly.
- Bypass (macro defined): empty FIFO, v_i=1, data_i=0x77, yumi_i=1 -> v_o=1, data_o=0x77 in the same cycle, and the FIFO is still empty on the next cycle.
